turbosound_multi: RTL

Parametrised multi-chip TurboSound block. It has CHIPS YM2149 cores on the CPU bus at FFFD/BFFD and chip selection via FFFD writes of 1111_1xxx. A common 1.75 MHz chip clock-enable has pause support. A built-in pipelined stereo mixer (mono/ABC/ACB) produces two summed, saturated channels for the audio DAC path.

---
 rtl/turbosound_multi_pkg.sv | 21 ++
 rtl/turbosound_multi_mixer.sv | 105 ++++++++++
 rtl/turbosound_multi_ym2149.sv | 87 ++++++++
 rtl/turbosound_multi.sv | 129 ++++++++++++
 4 files changed

// File: rtl/turbosound_multi_pkg.sv
// Shared types and constants for the multi-chip TurboSound block.
package turbosound_multi_pkg;

    typedef enum logic [1:0] {
        STEREO_MONO = 2'd0,
        STEREO_ABC  = 2'd1,
        STEREO_ACB  = 2'd2
    } stereo_mode_t;

    localparam int         TS_MAX_CHIPS  = 4;
    localparam logic [4:0] TS_SEL_PREFIX = 5'b11111;
    // Widest per-side sum: 382 per chip times TS_MAX_CHIPS = 1528.
    localparam int         TS_SUM_W      = 11;
    localparam int         YM_NREGS      = 16;

    // 4-bit amplitude spread over the full 8-bit channel range.
    function automatic logic [7:0] ym_level(input logic [3:0] vol);
        return {vol, vol};
    endfunction

endpackage

// File: rtl/turbosound_multi_mixer.sv
// Two-stage stereo mixer: stage 1 sums all unmuted chips per side in the
// selected stereo mode, stage 2 saturates to OUT_W and presents the sample.
module turbosound_mixer
    import turbosound_multi_pkg::*;
#(
    parameter int CHIPS = 2,
    parameter int OUT_W = 11
) (
    input  logic               clk28,
    input  logic               rst_n,
    input  logic               en,
    input  logic               launch,
    input  logic [1:0]         mode,
    input  logic [CHIPS-1:0]   mute,
    input  logic [CHIPS*8-1:0] ch_a,
    input  logic [CHIPS*8-1:0] ch_b,
    input  logic [CHIPS*8-1:0] ch_c,
    output logic [OUT_W-1:0]   out_l,
    output logic [OUT_W-1:0]   out_r,
    output logic               sample_stb
);

    localparam int EXT_W = (OUT_W > TS_SUM_W) ? OUT_W : TS_SUM_W;
    localparam logic [EXT_W-1:0] SAT_MAX = EXT_W'((64'd1 << OUT_W) - 64'd1);

    logic [TS_SUM_W-1:0] sum_l, sum_r, s1_l, s1_r;
    logic [TS_SUM_W-1:0] a, b, c, m;
    logic                s1_valid;
    logic [EXT_W-1:0]    ext_l, ext_r;
    logic [OUT_W-1:0]    sat_l, sat_r;

    // Per-side sums across unmuted chips; mode 3 falls back to ABC.
    always_comb begin
        sum_l = '0;
        sum_r = '0;
        a = '0;
        b = '0;
        c = '0;
        m = '0;
        for (int i = 0; i < CHIPS; i++) begin
            a = TS_SUM_W'(ch_a[i*8 +: 8]);
            b = TS_SUM_W'(ch_b[i*8 +: 8]);
            c = TS_SUM_W'(ch_c[i*8 +: 8]);
            m = (a + b + c) >> 1;
            if (!mute[i]) begin
                case (mode)
                    STEREO_MONO: begin
                        sum_l = sum_l + m;
                        sum_r = sum_r + m;
                    end
                    STEREO_ACB: begin
                        sum_l = sum_l + a + (c >> 1);
                        sum_r = sum_r + b + (c >> 1);
                    end
                    default: begin
                        sum_l = sum_l + a + (b >> 1);
                        sum_r = sum_r + c + (b >> 1);
                    end
                endcase
            end
        end
    end

    // Stage 1: capture sums (and thereby mode/mute) on the chip clock-enable.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_l     <= '0;
            s1_r     <= '0;
        end else if (!en) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= launch;
            if (launch) begin
                s1_l <= sum_l;
                s1_r <= sum_r;
            end
        end
    end

    assign ext_l = EXT_W'(s1_l);
    assign ext_r = EXT_W'(s1_r);
    assign sat_l = (ext_l > SAT_MAX) ? '1 : ext_l[OUT_W-1:0];
    assign sat_r = (ext_r > SAT_MAX) ? '1 : ext_r[OUT_W-1:0];

    // Stage 2: present the saturated sample; disable clears the outputs.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            out_l      <= '0;
            out_r      <= '0;
            sample_stb <= 1'b0;
        end else if (!en) begin
            out_l      <= '0;
            out_r      <= '0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= s1_valid;
            if (s1_valid) begin
                out_l <= sat_l;
                out_r <= sat_r;
            end
        end
    end

endmodule

// File: rtl/turbosound_multi_ym2149.sv
// Compact YM2149 core: 16-register file, address latch, three tone
// generators and a noise LFSR gated by the mixer register (R7). Channel
// level comes from the low four bits of R8..R10; the envelope generator
// is not modelled.
module ym2149
    import turbosound_multi_pkg::*;
(
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       addr_we,
    input  logic       data_we,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic [7:0] ch_a,
    output logic [7:0] ch_b,
    output logic [7:0] ch_c
);

    logic [7:0]  regs [YM_NREGS];
    logic [3:0]  addr;
    logic [11:0] tone_cnt [3];
    logic [2:0]  tone;
    logic [4:0]  noise_cnt;
    logic [16:0] lfsr;
    logic [7:0]  level [3];

    // Bus side: address latch and register writes.
    // NOTE: clocked state is always assigned with '<=' so every flop samples
    // the pre-edge values of its neighbours.
    // NOTE: the register file is tiny and must power up silent, so it is
    // reset like ordinary flops instead of being left as an unreset RAM.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            for (int i = 0; i < YM_NREGS; i++) regs[i] <= '0;
        end else if (addr_we) begin
            addr <= d_in[3:0];
        end else if (data_we) begin
            regs[addr] <= d_in;
        end
    end

    assign d_out = regs[addr];

    // Tone and noise generators advance on the shared chip clock-enable.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 3; n++) tone_cnt[n] <= '0;
            tone      <= '0;
            noise_cnt <= '0;
            lfsr      <= 17'd1;
        end else if (ena) begin
            for (int n = 0; n < 3; n++) begin
                if (tone_cnt[n] >= {regs[2*n+1][3:0], regs[2*n]}) begin
                    tone_cnt[n] <= '0;
                    tone[n]     <= ~tone[n];
                end else begin
                    tone_cnt[n] <= tone_cnt[n] + 12'd1;
                end
            end
            if (noise_cnt >= regs[6][4:0]) begin
                noise_cnt <= '0;
                lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
            end else begin
                noise_cnt <= noise_cnt + 5'd1;
            end
        end
    end

    // Channel level passes only while both tone and noise gates are open;
    // a set R7 bit forces the corresponding gate open.
    // NOTE: each level gets a default before the gated assignment so no
    // path through this block can infer a latch.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            level[n] = '0;
            if ((tone[n] | regs[7][n]) & (lfsr[0] | regs[7][n+3]))
                level[n] = ym_level(regs[8+n][3:0]);
        end
    end

    assign ch_a = level[0];
    assign ch_b = level[1];
    assign ch_c = level[2];

endmodule

// File: rtl/turbosound_multi.sv
// Multi-chip TurboSound: CHIPS YM2149 cores behind FFFD/BFFD, chip select
// via FFFD writes of 1111_1xxx, shared 1.75 MHz chip clock-enable with
// pause, and a built-in stereo mixer.
// Optional macro TURBOSOUND_MULTI_MUTE_EN adds the chip_mute input.
module turbosound_multi
    import turbosound_multi_pkg::*;
#(
    parameter int CHIPS  = 2,
    parameter int OUT_W  = 11,
    parameter int CLKDIV = 2
) (
    input  logic             clk28,
    input  logic             rst_n,
    input  logic             ck35,
    input  logic             en,
    input  logic [15:0]      a_reg,
    input  logic [7:0]       d_reg,
    input  logic             ioreq,
    input  logic             rd,
    input  logic             wr,
    output logic [7:0]       d_out,
    output logic             d_out_active,
    input  logic             pause,
    input  logic [1:0]       stereo_mode,
`ifdef TURBOSOUND_MULTI_MUTE_EN
    input  logic [CHIPS-1:0] chip_mute,
`endif
    output logic [OUT_W-1:0] out_l,
    output logic [OUT_W-1:0] out_r,
    output logic             sample_stb
);

    localparam logic [2:0] DIV_LAST = 3'(CLKDIV - 1);

    logic               port_fffd, port_bffd, bc1, bdir;
    logic               sel_wr, addr_we, data_we, ena;
    logic [1:0]         sel, sel_idx;
    logic [2:0]         div_cnt;
    logic [7:0]         chip_dout [CHIPS];
    logic [CHIPS*8-1:0] ch_a, ch_b, ch_c;
    logic [CHIPS-1:0]   mute;
    logic               unused_addr_bits;

    assign port_fffd = ioreq & a_reg[15] & a_reg[14] & ~a_reg[1];
    assign port_bffd = ioreq & a_reg[15] & ~a_reg[1];
    assign unused_addr_bits = ^{a_reg[13:2], a_reg[0]};

    assign sel_idx = ~d_reg[1:0];
    assign sel_wr  = port_fffd & wr & (d_reg[7:3] == TS_SEL_PREFIX);

    // Bus-phase flags feeding the cores, gated by the block enable.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            bc1  <= 1'b0;
            bdir <= 1'b0;
        end else begin
            bc1  <= en & port_fffd;
            bdir <= en & port_bffd & wr;
        end
    end

    // Chip select follows select writes even while disabled; out-of-range
    // indices leave it unchanged.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n)
            sel <= '0;
        else if (sel_wr && (int'(sel_idx) < CHIPS))
            sel <= sel_idx;
    end

    assign addr_we      = bc1 & bdir & (d_reg[7:3] != TS_SEL_PREFIX);
    assign data_we      = bdir & ~bc1;
    assign d_out_active = rd & bc1 & ~bdir;

    // Read data from the selected chip while a read is driven.
    always_comb begin
        d_out = '0;
        if (d_out_active)
            for (int i = 0; i < CHIPS; i++)
                if (sel == 2'(i)) d_out = chip_dout[i];
    end

    // Chip clock-enable divider: counts ck35 strobes, holds on pause/disable.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (ck35 & en & ~pause)
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 3'd1;
    end

    assign ena = ck35 & en & ~pause & (div_cnt == DIV_LAST);

    for (genvar g = 0; g < CHIPS; g++) begin : g_chip
        ym2149 u_ym (
            .clk28   (clk28),
            .rst_n   (rst_n),
            .ena     (ena),
            .addr_we (addr_we && (sel == 2'(g))),
            .data_we (data_we && (sel == 2'(g))),
            .d_in    (d_reg),
            .d_out   (chip_dout[g]),
            .ch_a    (ch_a[g*8 +: 8]),
            .ch_b    (ch_b[g*8 +: 8]),
            .ch_c    (ch_c[g*8 +: 8])
        );
    end

`ifdef TURBOSOUND_MULTI_MUTE_EN
    assign mute = chip_mute;
`else
    assign mute = '0;
`endif

    turbosound_mixer #(.CHIPS(CHIPS), .OUT_W(OUT_W)) u_mixer (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .en         (en),
        .launch     (ena),
        .mode       (stereo_mode),
        .mute       (mute),
        .ch_a       (ch_a),
        .ch_b       (ch_b),
        .ch_c       (ch_c),
        .out_l      (out_l),
        .out_r      (out_r),
        .sample_stb (sample_stb)
    );

endmodule
